// File: rtl/mux_rr_arbiter_pkg.sv
// Shared helpers for the round-robin mux arbiter: rotating find-first search
// and the requester-count legality check used at elaboration.
package mux_rr_arbiter_pkg;

    // Widest requester vector the find-first search handles.
    localparam int RR_MAX = 64;

    // Returns true when r is a power of two, at least 2, and within RR_MAX.
    function automatic bit rr_r_legal(input int r);
        return (r >= 2) && (r <= RR_MAX) && ((r & (r - 1)) == 0);
    endfunction

    // Rotate the valid vector so ptr sits at bit 0, priority-encode the lowest
    // set bit, then un-rotate back to a requester index. Returns -1 if none.
    function automatic int rr_find_first(input logic [RR_MAX-1:0] valid,
                                         input int                ptr,
                                         input int                r);
        logic [RR_MAX-1:0] rot;
        int                hit;
        rot = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            if (i < r) rot[i] = valid[(i + ptr) % r];
        end
        hit = -1;
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            if (rot[i]) hit = i;
        end
        return (hit < 0) ? -1 : (hit + ptr) % r;
    endfunction

endpackage

// File: rtl/mux_rr_tree.sv
// Combinational binary tree of 2:1 select cells picking one of R lanes.
// Latency: 0 cycles. Backpressure: none, pure datapath.
// Select bit k drives tree level k, with bit 0 at the leaf level.
module mux_rr_tree #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic [R*N-1:0]       leaf_data,
    input  logic [$clog2(R)-1:0] sel,
    output logic [N-1:0]         mux_data
);
    localparam int GW = $clog2(R);

    // Heap layout: node 1 is the root, leaves sit at R .. 2R-1.
    logic [N-1:0] node [1:2*R-1];

    for (genvar i = 0; i < R; i++) begin : g_leaf
        assign node[R+i] = leaf_data[i*N +: N];
    end

    for (genvar j = 1; j < R; j++) begin : g_cell
        localparam int DEPTH = $clog2(j + 1) - 1;
        logic [N-1:0] a;
        logic [N-1:0] b;
        assign a = node[2*j];
        assign b = node[2*j+1];
        // One AND per bit: O = ((A^B)&S)^A.
        assign node[j] = ((a ^ b) & {N{sel[GW-1-DEPTH]}}) ^ a;
    end

    assign mux_data = node[1];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one N-bit mux-tree datapath among R valid/ready requesters.
// Latency: 1 cycle accept-to-out_valid; full throughput, output refills while draining.
// Backpressure: out_ready low freezes the output register and zeroes all req_ready.
// Optional burst lock via MUX_RR_ARBITER_BURST_LOCK_EN (adds req_last).
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req_valid,
    input  logic [R*N-1:0]       req_data,
`ifdef MUX_RR_ARBITER_BURST_LOCK_EN
    input  logic [R-1:0]         req_last,
`endif
    output logic [R-1:0]         req_ready,
    output logic                 out_valid,
    output logic [N-1:0]         out_data,
    output logic [$clog2(R)-1:0] out_grant,
    input  logic                 out_ready
);
    localparam int GW = $clog2(R);

    if (!rr_r_legal(R)) begin : g_bad_r
        $error("mux_rr_arbiter: R must be a power of two between 2 and RR_MAX");
    end

    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] win_idx;
    logic          win_vld;
    logic          can_accept;
    logic          accept;
    logic [N-1:0]  tree_data;
    int            pick;

`ifdef MUX_RR_ARBITER_BURST_LOCK_EN
    logic          lock;
    logic [GW-1:0] locked_id;
`endif

    assign can_accept = !out_valid || out_ready;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        pick    = rr_find_first(RR_MAX'(req_valid), int'(rr_ptr), R);
        if (pick >= 0) begin
            win_vld = 1'b1;
            win_idx = GW'(pick);
        end
`ifdef MUX_RR_ARBITER_BURST_LOCK_EN
        // A locked burst owner wins outright; if it drops valid nobody is granted.
        if (lock) begin
            win_vld = req_valid[locked_id];
            win_idx = locked_id;
        end
`endif
    end

    // Gating with rst keeps req_ready low for the whole reset window.
    assign accept = win_vld && can_accept && rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win_idx] = 1'b1;
    end

    mux_rr_tree #(
        .N (N),
        .R (R)
    ) u_tree (
        .leaf_data (req_data),
        .sel       (win_idx),
        .mux_data  (tree_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= tree_data;
            out_grant <= win_idx;
`ifdef MUX_RR_ARBITER_BURST_LOCK_EN
            if (req_last[win_idx]) rr_ptr <= win_idx + 1'b1;
`else
            rr_ptr    <= win_idx + 1'b1;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_RR_ARBITER_BURST_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock      <= 1'b0;
            locked_id <= '0;
        end else if (accept) begin
            lock      <= !req_last[win_idx];
            locked_id <= win_idx;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a cycle model checked on every falling edge
// plus hand-computed literal expectations for each scenario.
module tb_mux_rr_arbiter;
    localparam int N  = 8;
    localparam int R  = 4;
    localparam int GW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [R-1:0]  req_valid;
    logic [R*N-1:0] req_data;
    logic [R-1:0]  req_last;
    logic [R-1:0]  req_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic [GW-1:0] out_grant;
    logic          out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef MUX_RR_ARBITER_BURST_LOCK_EN
        .req_last  (req_last),
`endif
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_grant (out_grant),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: what the output register and pointer must hold.
    logic         m_vld  = 1'b0;
    logic [N-1:0] m_dat  = '0;
    int           m_gnt  = 0;
    int           m_ptr  = 0;
    logic         m_lock = 1'b0;
    int           m_lid  = 0;

    function automatic int model_winner();
        if (rst !== 1'b1) return -1;
`ifdef MUX_RR_ARBITER_BURST_LOCK_EN
        if (m_lock) return req_valid[m_lid] ? m_lid : -1;
`endif
        for (int off = 0; off < R; off++) begin
            if (req_valid[(m_ptr + off) % R]) return (m_ptr + off) % R;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        int w;
        if (!rst) begin
            m_vld = 1'b0; m_dat = '0; m_gnt = 0; m_ptr = 0; m_lock = 1'b0; m_lid = 0;
        end else begin
            w = model_winner();
            if (w >= 0 && (!m_vld || out_ready)) begin
                m_dat = req_data[w*N +: N];
                m_gnt = w;
                m_vld = 1'b1;
`ifdef MUX_RR_ARBITER_BURST_LOCK_EN
                if (req_last[w]) begin
                    m_ptr  = (w + 1) % R;
                    m_lock = 1'b0;
                end else begin
                    m_lock = 1'b1;
                    m_lid  = w;
                end
`else
                m_ptr = (w + 1) % R;
`endif
            end else if (out_ready) begin
                m_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int           w;
        logic [R-1:0] er;
        w  = model_winner();
        er = '0;
        if (w >= 0 && (!m_vld || out_ready)) er[w] = 1'b1;
        chk("model_req_ready", 32'(req_ready), 32'(er));
        chk("model_out_valid", 32'(out_valid), 32'(m_vld));
        chk("model_out_data",  32'(out_data),  32'(m_dat));
        chk("model_out_grant", 32'(out_grant), m_gnt);
    end

    task automatic set_data(input logic [N-1:0] base);
        for (int i = 0; i < R; i++) req_data[i*N +: N] = base + N'(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b1;
        set_data(8'hA0);

        repeat (3) begin
            tick();
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_data",  32'(out_data),  0);
        end
        rst = 1'b1;

        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_grant", 32'(out_grant), k % 4);
            chk("rr_data",  32'(out_data),  8'hA0 + k % 4);
        end

        req_valid = 4'b0001;
        req_data[7:0] = 8'h5C;
        tick();
        chk("bp_load_data", 32'(out_data), 8'h5C);
        out_ready = 1'b0;
        req_valid = 4'b1111;
        req_data[7:0] = 8'hA0;
        repeat (4) begin
            tick();
            chk("bp_hold_data",  32'(out_data),  8'h5C);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_req_ready",  32'(req_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 4'b0010);
        tick();
        chk("bp_next_grant", 32'(out_grant), 1);
        chk("bp_next_data",  32'(out_data),  8'hA1);

        tick();
        chk("pre_wrap_grant", 32'(out_grant), 2);
        req_valid = 4'b0010;
        tick();
        chk("sparse_grant", 32'(out_grant), 1);
        req_valid = 4'b1001;
        tick();
        chk("wrap_grant_3", 32'(out_grant), 3);
        tick();
        chk("wrap_grant_0", 32'(out_grant), 0);
        req_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_data",  32'(out_data),  8'hA0);
        chk("drain_grant", 32'(out_grant), 0);
        tick();
        req_valid = 4'b1111;
        tick();
        chk("idle_ptr_grant", 32'(out_grant), 1);

        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_req_ready", 32'(req_ready), 0);
        chk("arst_out_data",  32'(out_data),  0);
        tick();
        rst = 1'b1;
        tick();
        chk("arst_first_grant", 32'(out_grant), 0);
        chk("arst_first_data",  32'(out_data),  8'hA0);

`ifdef MUX_RR_ARBITER_BURST_LOCK_EN
        req_valid = 4'b0101;
        req_last  = 4'b1011;
        tick();
        chk("burst_beat0", 32'(out_grant), 2);
        tick();
        chk("burst_beat1", 32'(out_grant), 2);
        req_last = 4'b1111;
        tick();
        chk("burst_beat2", 32'(out_grant), 2);
        tick();
        chk("burst_after", 32'(out_grant), 0);
`endif

        // Fixed table of mixed valid / ready / last patterns, checked by the model.
        for (int c = 0; c < 48; c++) begin
            req_valid = 4'((c * 7) ^ (c >> 2));
            out_ready = (c % 5) != 2;
            req_last  = 4'(c * 3) | 4'b0001;
            set_data(8'(c * 16));
            tick();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
